// File: rtl/alu_arb_defs.sv
// alu_arb_defs: shared widths, ALU op codes, FSM encodings and tie-break helper for alu_arbiter.
package alu_arb_defs;
    localparam int OP_W = 3;
    localparam int W_DEF = 32;
    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_SLT = 3'd5;
    localparam logic [OP_W-1:0] OP_SLL = 3'd6;
    localparam logic [OP_W-1:0] OP_SRL = 3'd7;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;
    // Fixed priority favours requester 0; round-robin hands a tie to whoever did not win last.
    function automatic logic pick_req1(input logic r0, input logic r1, input logic last, input logic rr);
        return (r0 && r1) ? (rr && !last) : r1;
    endfunction
endpackage

// File: rtl/alu_arbiter_alu.sv
// ALU: combinational ALU shared by the arbiter (add/sub/and/or/xor/slt/sll/srl, zero and signed-overflow flags).
module ALU
    import alu_arb_defs::*;
#(
    parameter int W = W_DEF
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [W-1:0]    f,
    output logic            zf,
    output logic            of
);
    localparam int SW = $clog2(W);
    logic [W-1:0] sum, dif;
    logic lt;
    assign sum = a + b;
    assign dif = a - b;
    assign lt = $signed(a) < $signed(b);
    assign f = op == OP_ADD ? sum :
               op == OP_SUB ? dif :
               op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_XOR ? a ^ b :
               op == OP_SLT ? {{(W-1){1'b0}}, lt} :
               op == OP_SLL ? a << b[SW-1:0] :
                              a >> b[SW-1:0];
    assign zf = f == '0;
    assign of = op == OP_ADD ? (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]) :
                op == OP_SUB ? (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]) : 1'b0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with a valid/ready response port.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; fixed priority to requester 0 otherwise.
module alu_arbiter
    import alu_arb_defs::*;
#(
    parameter int W = W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic [OP_W-1:0] op0,
    input  logic [OP_W-1:0] op1,
    input  logic [W-1:0]    a0,
    input  logic [W-1:0]    b0,
    input  logic [W-1:0]    a1,
    input  logic [W-1:0]    b1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            busy,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_f,
    output logic            rsp_zf,
    output logic            rsp_of
);
`ifdef ALU_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif
    state_t state;
    logic [OP_W-1:0] op_r;
    logic [W-1:0] a_r, b_r, alu_f;
    logic id_r, last_id, alu_zf, alu_of, pick1, go;
    assign pick1 = pick_req1(req0, req1, last_id, RR_EN);
    assign go = (state == S_IDLE) && (req0 || req1);
    assign gnt0 = go && !pick1;
    assign gnt1 = go && pick1;
    assign busy = state != S_IDLE;
    assign rsp_valid = state == S_RESP;
    ALU #(.W(W)) alu1 (
        .op(op_r),
        .a (a_r),
        .b (b_r),
        .f (alu_f),
        .zf(alu_zf),
        .of(alu_of)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_r <= '0;
            a_r <= '0;
            b_r <= '0;
            id_r <= 1'b0;
            last_id <= 1'b1;
            rsp_id <= 1'b0;
            rsp_f <= '0;
            rsp_zf <= 1'b0;
            rsp_of <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (go) begin
                    op_r <= pick1 ? op1 : op0;
                    a_r <= pick1 ? a1 : a0;
                    b_r <= pick1 ? b1 : b0;
                    id_r <= pick1;
                    last_id <= pick1;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    rsp_f <= alu_f;
                    rsp_zf <= alu_zf;
                    rsp_of <= alu_of;
                    rsp_id <= id_r;
                    state <= S_RESP;
                end
                S_RESP: if (rsp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table vectors, directed corner sequences and random traffic against a behavioural model.
module tb_alu_arbiter;
`ifdef ALU_ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 0, req1 = 0, rsp_ready = 0;
    logic [2:0] op0 = 0, op1 = 0;
    logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic gnt0, gnt1, busy, rsp_valid, rsp_id, rsp_zf, rsp_of;
    logic [31:0] rsp_f;
    logic m_last;
    int total = 0, bad = 0;

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] a, b, f;
        logic        zf, of;
    } vec_t;
    vec_t tbl[10];

    alu_arbiter #(.W(32)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_f(rsp_f), .rsp_zf(rsp_zf), .rsp_of(rsp_of)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference ALU from signed integer arithmetic; result packed as {of, zf, f}.
    function automatic logic [33:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        logic [31:0] f;
        logic of;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0;
        of = 1'b0;
        case (op)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            default: r = 0;
        endcase
        if (op <= 3'd1) of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        case (op)
            3'd0, 3'd1: f = r[31:0];
            3'd2: f = a & b;
            3'd3: f = a | b;
            3'd4: f = a ^ b;
            3'd5: f = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: f = a << b[4:0];
            default: f = a >> b[4:0];
        endcase
        return {of, f == 32'd0, f};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        req0 = 0; req1 = 0; rsp_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        m_last = 1'b1;
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt0"}, gnt0, 0);
        chk({nm, "_gnt1"}, gnt1, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_valid"}, rsp_valid, 0);
        chk({nm, "_id"}, rsp_id, 0);
        chk({nm, "_f"}, rsp_f, 0);
        chk({nm, "_zf"}, rsp_zf, 0);
        chk({nm, "_of"}, rsp_of, 0);
    endtask

    // One full operation from IDLE; returns the winner and what the response port showed.
    task automatic txn(input logic r0, input logic r1, input logic [2:0] o0, input logic [2:0] o1,
                       input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] x1,
                       input logic [31:0] y1, input int stall, output logic wid,
                       output logic [31:0] f, output logic zf, output logic of);
        logic e1;
        logic [33:0] e;
        e1 = (r0 && r1) ? (RR && !m_last) : r1;
        e = e1 ? ref_alu(o1, x1, y1) : ref_alu(o0, x0, y0);
        req0 = r0; req1 = r1; op0 = o0; op1 = o1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        rsp_ready = 0;
        #1;
        chk("grant0", gnt0, r0 && !e1);
        chk("grant1", gnt1, e1);
        chk("idle_busy", busy, 0);
        m_last = e1;
        wid = e1;
        @(posedge clk);
        @(negedge clk);
        req0 = 0; req1 = 0;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom; op0 = 3'($urandom); op1 = 3'($urandom);
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_valid", rsp_valid, 0);
        chk("exec_gnt", {gnt0, gnt1}, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        f = rsp_f; zf = rsp_zf; of = rsp_of;
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                @(posedge clk);
                @(negedge clk);
                #1;
            end
            chk("resp_valid", rsp_valid, 1);
            chk("resp_busy", busy, 1);
            chk("resp_id", rsp_id, e1);
            chk("resp_f", rsp_f, e[31:0]);
            chk("resp_zf", rsp_zf, e[32]);
            chk("resp_of", rsp_of, e[33]);
        end
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        #1;
        chk("done_valid", rsp_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    initial begin
        logic w, zf, of;
        logic [31:0] f, x, y;
        logic [31:0] specials[4];
        logic r0, r1;
        tbl[0] = '{0, 3'd0, 32'h00000003, 32'h00000607, 32'h0000060A, 0, 0};
        tbl[1] = '{1, 3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0};
        tbl[2] = '{0, 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1};
        tbl[3] = '{1, 3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1};
        tbl[4] = '{0, 3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0};
        tbl[5] = '{1, 3'd3, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 0, 0};
        tbl[6] = '{0, 3'd4, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1, 0};
        tbl[7] = '{1, 3'd5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0};
        tbl[8] = '{0, 3'd6, 32'h00000001, 32'h0000001F, 32'h80000000, 0, 0};
        tbl[9] = '{1, 3'd7, 32'h80000000, 32'h00000004, 32'h08000000, 0, 0};
        specials = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

        do_reset();
        chk_zero("reset");

        foreach (tbl[i]) begin
            txn(!tbl[i].id, tbl[i].id, tbl[i].op, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].a, tbl[i].b,
                i % 3, w, f, zf, of);
            chk("tbl_id", w, tbl[i].id);
            chk("tbl_f", f, tbl[i].f);
            chk("tbl_zf", zf, tbl[i].zf);
            chk("tbl_of", of, tbl[i].of);
        end

        for (int op = 0; op < 8; op++)
            for (int k = 0; k < 2; k++) begin
                x = k ? 32'h80000000 : 32'h7FFFFFFF;
                txn(0, 1, 3'(op), 3'(op), 32'h0, 32'h0, x, x, 0, w, f, zf, of);
            end

        // Ties held high: round-robin alternates, fixed priority always picks 0.
        do_reset();
        req0 = 1; req1 = 1; op0 = 3'd0; op1 = 3'd1; a0 = 1; b0 = 1; a1 = 9; b1 = 4;
        rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            for (int t = 0; t < 6 && !(gnt0 || gnt1); t++) begin
                @(posedge clk);
                @(negedge clk);
                #1;
            end
            chk("tie_seen", gnt0 || gnt1, 1);
            chk("tie_one", gnt0 && gnt1, 0);
            chk("tie_win", gnt1, RR ? k % 2 : 0);
            @(posedge clk);
            @(negedge clk);
        end
        req0 = 0; req1 = 0;
        for (int t = 0; t < 6 && busy; t++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 0;
        #1;
        chk("tie_drain", busy, 0);

        // Backpressure with requester 1 waiting.
        do_reset();
        req0 = 1; op0 = 3'd0; a0 = 1; b0 = 2;
        #1;
        chk("bp_gnt0", gnt0, 1);
        @(posedge clk);
        @(negedge clk);
        req0 = 0; req1 = 1; op1 = 3'd1; a1 = 10; b1 = 3;
        #1;
        chk("bp_exec_gnt1", gnt1, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("bp_valid", rsp_valid, 1);
        for (int s = 0; s < 5; s++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_busy", busy, 1);
            chk("bp_hold_f", rsp_f, 3);
            chk("bp_hold_id", rsp_id, 0);
            chk("bp_hold_gnt1", gnt1, 0);
        end
        rsp_ready = 1;
        #1;
        chk("bp_ready_gnt1", gnt1, 0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        #1;
        chk("bp_next_gnt1", gnt1, 1);
        @(posedge clk);
        @(negedge clk);
        req1 = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("bp2_f", rsp_f, 7);
        chk("bp2_id", rsp_id, 1);
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;

        // Reset while in EXEC (k=0) or RESP (k=1).
        for (int k = 0; k < 2; k++) begin
            do_reset();
            req0 = 1; op0 = 3'd4; a0 = 32'h1234; b0 = 32'h4321;
            @(posedge clk);
            @(negedge clk);
            req0 = 0;
            if (k == 1) begin
                @(posedge clk);
                @(negedge clk);
                #1;
                chk("rr_pre_valid", rsp_valid, 1);
            end
            rst = 1;
            @(posedge clk);
            @(negedge clk);
            rst = 0;
            #1;
            chk_zero(k ? "rst_resp" : "rst_exec");
            for (int t = 0; t < 3; t++) begin
                @(posedge clk);
                @(negedge clk);
                #1;
                chk("rst_stale_valid", rsp_valid, 0);
                chk("rst_stale_busy", busy, 0);
            end
            m_last = 1'b1;
        end

        // Requester 0 pulses only while busy and must never be granted.
        req1 = 1; op1 = 3'd0; a1 = 5; b1 = 6;
        #1;
        chk("wd_gnt1", gnt1, 1);
        @(posedge clk);
        @(negedge clk);
        req1 = 0; req0 = 1;
        #1;
        chk("wd_exec_gnt0", gnt0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("wd_resp_gnt0", gnt0, 0);
        req0 = 0; rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        for (int t = 0; t < 3; t++) begin
            #1;
            chk("wd_idle_gnt0", gnt0, 0);
            @(posedge clk);
            @(negedge clk);
        end
        m_last = 1'b1;

        for (int n = 0; n < 40; n++) begin
            r0 = 1'($urandom); r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1;
            x = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            txn(r0, r1, 3'($urandom), 3'($urandom), x, y, y ^ $urandom, $urandom, $urandom_range(0, 3),
                w, f, zf, of);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
